riscv_pipe_scoreboard: RTL and testbench
========================================

Name: riscv_pipe_scoreboard

Overview:
- Parametrised hazard controller for the 5-stage RV32 pipeline. Successor to the fixed load-use/forward hazard logic.
- Adds three capabilities:
  - a register scoreboard for one outstanding variable-latency multi-cycle unit (MUL/DIV) with start/done handshake;
  - WAW protection against late multi-cycle write-back;
  - a compile-time forwarding disable (stall-only mode).
- Sits beside the datapath. It drives stall/flush enables of the PC, F/D and D/E registers, and the two operand forward muxes.
- Also keeps a saturating stall-cycle performance counter.

Parameters:
- N_REG, 32, architectural register count; index 0 is hardwired zero.
- REG_AW, 5, register address width, equal to clog2(N_REG).
- FWD_EN, 1, 1 = M/W forwarding enabled; 0 = stall on any RAW hit in E/M.
- CNT_W, 16, width of the stall performance counter.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_sb_valid_d  in  1  D stage holds a valid instruction
- i_sb_rs1_addr_d, i_sb_rs2_addr_d  in  REG_AW  D source addresses
- i_sb_rs1_used_d, i_sb_rs2_used_d  in  1  D source actually read
- i_sb_rd_addr_d  in  REG_AW  D destination
- i_sb_reg_wr_en_d  in  1  D instruction writes rd
- i_sb_mc_d  in  1  D instruction is multi-cycle
- i_sb_valid_e  in  1  E stage valid (cleared by flush)
- i_sb_rs1_addr_e, i_sb_rs2_addr_e, i_sb_rd_addr_e  in  REG_AW  E addresses
- i_sb_reg_wr_en_e, i_sb_load_e, i_sb_mc_e  in  1  E write enable, load, multi-cycle
- i_sb_redirect_e  in  1  taken branch/jump resolved in E
- i_sb_rd_addr_m, i_sb_rd_addr_w  in  REG_AW  M and W destinations
- i_sb_reg_wr_en_m, i_sb_reg_wr_en_w  in  1  M and W write enables
- i_sb_mc_done  in  1  multi-cycle unit result written this cycle
- i_sb_cnt_clr  in  1  clear the stall counter
- o_sb_stall_f, o_sb_stall_d  out  1  hold the PC / hold F/D
- o_sb_flush_d, o_sb_flush_e  out  1  clear F/D / clear D/E
- o_sb_forward_ae, o_sb_forward_be  out  2  forward select: 00 regfile, 01 W result, 10 M result
- o_sb_mc_start  out  1  one-cycle start pulse to the multi-cycle unit
- o_sb_mc_busy  out  1  multi-cycle unit outstanding
- o_sb_pending  out  N_REG  scoreboard bit vector
- o_sb_stall_cnt  out  CNT_W  saturating stall-cycle count

Behaviour:
- Reset: all outputs 0 on the first rising edge with i_rst=1. This includes pending, the counter and forward selects (00). The FSM goes to IDLE.
- Address 0 never matches: no forward, no stall, no pending set.
- Forwarding (combinational, E stage), per operand:
  - 10 if FWD_EN and reg_wr_en_m and rd_m==rs_e;
  - else 01 if FWD_EN and reg_wr_en_w and rd_w==rs_e;
  - else 00. M has priority over W.
- D-stage stall condition stall_d, the OR of:
  - Load-use: valid_e & load_e & rd_e equals a used D source.
  - FWD_EN=0: a used D source matches a writing E or M rd.
  - RAW on pending: a used D source has its pending bit set.
  - WAW on pending: reg_wr_en_d & pending[rd_d].
  - Structural: mc_d & (busy | o_sb_mc_start).
  - All terms are gated by valid_d.
- Outputs from stall and redirect:
  - o_sb_stall_f = o_sb_stall_d = stall_d & ~redirect_e. Redirect wins over a stall.
  - o_sb_flush_d = redirect_e.
  - o_sb_flush_e = redirect_e | stall_d. This inserts a bubble.
- FSM IDLE→BUSY:
  - Trigger: valid_e & mc_e in IDLE.
  - o_sb_mc_start=1 for exactly that cycle.
  - pending[rd_e] is set at the edge when reg_wr_en_e and rd_e≠0.
- FSM BUSY→IDLE:
  - Trigger: i_sb_mc_done.
  - The pending bit set at issue is cleared at the edge. The destination is held in an internal REG_AW register.
- i_sb_mc_done in IDLE is ignored.
- Done and a new start cannot coincide, because the structural stall prevents it. If they coincide anyway, set wins over clear for the same index.
- Reset mid-BUSY: FSM to IDLE, pending cleared, and a late done is ignored.
- o_sb_mc_busy = (state==BUSY), registered.
- Stall counter: increments each cycle o_sb_stall_d=1 and saturates at all-ones. i_sb_cnt_clr zeroes it and has priority over increment.

Decomposition:
- riscv_configs.v gets:
  - the forward encodings (FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10);
  - the FSM encodings (SB_IDLE, SB_BUSY).
- One sub-module, riscv_sb_fwd_sel: combinational per-operand forward select, instantiated twice (rs1, rs2). The FSM, pending vector and counter stay in the top.

Test Plan:
- lw x5 in E, add x6,x5,x1 in D → stall_f=stall_d=1, flush_e=1 for one cycle; next cycle forward_ae=10 is forbidden (the load has reached W), forward_ae=01.
- add x3 in M, sub using rs2=x3 in E, x3 also in W → forward_be=10 (M priority). Same with rs=x0 → 00.
- div x7 issues in E → mc_start pulse, pending[7]=1, busy=1. A dependent in D stalls until mc_done; pending[7]=0 the cycle after, and the stall drops.
- mul in BUSY state arriving in D → stalled. addi x7 (WAW) in D while pending[7]=1 → stalled.
- redirect_e with a load-use stall active → stall_f=0, flush_d=1, flush_e=1.
- FWD_EN=0 build: add x4 in M, D reads x4 → stall. i_rst asserted mid-BUSY → busy=0, pending=0, counter=0, and a later mc_done has no effect.
- Counter preset near 16'hFFFF with continuous stall → holds at 16'hFFFF. cnt_clr → 0.

Source files
------------

// File: rtl/riscv_pipe_scoreboard_pkg.sv
// Shared encodings for the pipeline hazard scoreboard: operand forward
// selects and the multi-cycle unit tracking FSM states.
package riscv_pipe_scoreboard_pkg;

  // Operand forward mux selects
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // Multi-cycle unit tracking states
  typedef logic [0:0] sb_state_t;
  localparam sb_state_t SB_IDLE = 1'b0;
  localparam sb_state_t SB_BUSY = 1'b1;

endpackage

// File: rtl/riscv_pipe_scoreboard_fwd_sel.sv
// Per-operand E-stage forward select. M beats W because it holds the younger
// write to the same register; x0 never forwards.
module riscv_sb_fwd_sel
  import riscv_pipe_scoreboard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int FWD_EN = 1
) (
  input  logic [REG_AW-1:0] rs_addr_i,
  input  logic [REG_AW-1:0] rd_addr_m_i,
  input  logic [REG_AW-1:0] rd_addr_w_i,
  input  logic              reg_wr_en_m_i,
  input  logic              reg_wr_en_w_i,
  output logic [1:0]        fwd_sel_o
);

  // Priority select of the youngest in-flight producer
  always_comb begin
    fwd_sel_o = FWD_RF;
    if ((FWD_EN != 0) && (rs_addr_i != '0)) begin
      if (reg_wr_en_m_i && (rd_addr_m_i == rs_addr_i)) begin
        fwd_sel_o = FWD_M;
      end else if (reg_wr_en_w_i && (rd_addr_w_i == rs_addr_i)) begin
        fwd_sel_o = FWD_W;
      end
    end
  end

endmodule

// File: rtl/riscv_pipe_scoreboard.sv
// Hazard controller for the 5-stage RV32 pipeline: load-use and RAW/WAW
// stalls, operand forwarding, tracking of one outstanding multi-cycle
// (MUL/DIV) operation and a saturating stall-cycle counter.
module riscv_pipe_scoreboard
  import riscv_pipe_scoreboard_pkg::*;
#(
  parameter int N_REG  = 32,
  parameter int REG_AW = 5,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_sb_valid_d,
  input  logic [REG_AW-1:0] i_sb_rs1_addr_d,
  input  logic [REG_AW-1:0] i_sb_rs2_addr_d,
  input  logic              i_sb_rs1_used_d,
  input  logic              i_sb_rs2_used_d,
  input  logic [REG_AW-1:0] i_sb_rd_addr_d,
  input  logic              i_sb_reg_wr_en_d,
  input  logic              i_sb_mc_d,
  input  logic              i_sb_valid_e,
  input  logic [REG_AW-1:0] i_sb_rs1_addr_e,
  input  logic [REG_AW-1:0] i_sb_rs2_addr_e,
  input  logic [REG_AW-1:0] i_sb_rd_addr_e,
  input  logic              i_sb_reg_wr_en_e,
  input  logic              i_sb_load_e,
  input  logic              i_sb_mc_e,
  input  logic              i_sb_redirect_e,
  input  logic [REG_AW-1:0] i_sb_rd_addr_m,
  input  logic [REG_AW-1:0] i_sb_rd_addr_w,
  input  logic              i_sb_reg_wr_en_m,
  input  logic              i_sb_reg_wr_en_w,
  input  logic              i_sb_mc_done,
  input  logic              i_sb_cnt_clr,
  output logic              o_sb_stall_f,
  output logic              o_sb_stall_d,
  output logic              o_sb_flush_d,
  output logic              o_sb_flush_e,
  output logic [1:0]        o_sb_forward_ae,
  output logic [1:0]        o_sb_forward_be,
  output logic              o_sb_mc_start,
  output logic              o_sb_mc_busy,
  output logic [N_REG-1:0]  o_sb_pending,
  output logic [CNT_W-1:0]  o_sb_stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  sb_state_t         state_q, state_d;
  logic [N_REG-1:0]  pending_q, pending_d;
  logic [REG_AW-1:0] mc_rd_q, mc_rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic busy;
  logic load_use, raw_nofwd, raw_pend, waw_pend, struct_mc;
  logic stall_d;

  // Register address match that never fires on x0
  function automatic logic reg_hit(input logic [REG_AW-1:0] a,
                                   input logic [REG_AW-1:0] b);
    return (a == b) && (a != '0);
  endfunction

  // Counter increment that sticks at all-ones
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  riscv_sb_fwd_sel #(.REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_fwd_a (
    .rs_addr_i     (i_sb_rs1_addr_e),
    .rd_addr_m_i   (i_sb_rd_addr_m),
    .rd_addr_w_i   (i_sb_rd_addr_w),
    .reg_wr_en_m_i (i_sb_reg_wr_en_m),
    .reg_wr_en_w_i (i_sb_reg_wr_en_w),
    .fwd_sel_o     (o_sb_forward_ae)
  );

  riscv_sb_fwd_sel #(.REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_fwd_b (
    .rs_addr_i     (i_sb_rs2_addr_e),
    .rd_addr_m_i   (i_sb_rd_addr_m),
    .rd_addr_w_i   (i_sb_rd_addr_w),
    .reg_wr_en_m_i (i_sb_reg_wr_en_m),
    .reg_wr_en_w_i (i_sb_reg_wr_en_w),
    .fwd_sel_o     (o_sb_forward_be)
  );

  assign busy          = (state_q == SB_BUSY);
  assign o_sb_mc_busy  = busy;
  assign o_sb_mc_start = (state_q == SB_IDLE) & i_sb_valid_e & i_sb_mc_e;

  // D-stage hazard detection; every term is qualified by a valid D slot
  always_comb begin
    load_use  = i_sb_valid_e & i_sb_load_e &
                ((i_sb_rs1_used_d & reg_hit(i_sb_rs1_addr_d, i_sb_rd_addr_e)) |
                 (i_sb_rs2_used_d & reg_hit(i_sb_rs2_addr_d, i_sb_rd_addr_e)));
    raw_nofwd = (FWD_EN == 0) &
                ((i_sb_valid_e & i_sb_reg_wr_en_e &
                  ((i_sb_rs1_used_d & reg_hit(i_sb_rs1_addr_d, i_sb_rd_addr_e)) |
                   (i_sb_rs2_used_d & reg_hit(i_sb_rs2_addr_d, i_sb_rd_addr_e)))) |
                 (i_sb_reg_wr_en_m &
                  ((i_sb_rs1_used_d & reg_hit(i_sb_rs1_addr_d, i_sb_rd_addr_m)) |
                   (i_sb_rs2_used_d & reg_hit(i_sb_rs2_addr_d, i_sb_rd_addr_m)))));
    raw_pend  = (i_sb_rs1_used_d & pending_q[i_sb_rs1_addr_d]) |
                (i_sb_rs2_used_d & pending_q[i_sb_rs2_addr_d]);
    waw_pend  = i_sb_reg_wr_en_d & pending_q[i_sb_rd_addr_d];
    struct_mc = i_sb_mc_d & (busy | o_sb_mc_start);
    stall_d   = i_sb_valid_d &
                (load_use | raw_nofwd | raw_pend | waw_pend | struct_mc);
  end

  // A redirect discards the D instruction, so it overrides the hold
  assign o_sb_stall_f = stall_d & ~i_sb_redirect_e;
  assign o_sb_stall_d = stall_d & ~i_sb_redirect_e;
  assign o_sb_flush_d = i_sb_redirect_e;
  assign o_sb_flush_e = i_sb_redirect_e | stall_d;

  // Next state for the multi-cycle FSM, pending vector and stall counter
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    mc_rd_d   = mc_rd_q;
    if (busy && i_sb_mc_done) begin
      state_d            = SB_IDLE;
      pending_d[mc_rd_q] = 1'b0;
    end
    if (o_sb_mc_start) begin
      state_d = SB_BUSY;
      // A non-writing op records x0 so its completion clears nothing
      mc_rd_d = i_sb_reg_wr_en_e ? i_sb_rd_addr_e : '0;
      if (i_sb_reg_wr_en_e && (i_sb_rd_addr_e != '0)) begin
        pending_d[i_sb_rd_addr_e] = 1'b1;
      end
    end
    cnt_d = cnt_q;
    if (i_sb_cnt_clr) begin
      cnt_d = '0;
    end else if (o_sb_stall_d) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= SB_IDLE;
      pending_q <= '0;
      mc_rd_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      mc_rd_q   <= mc_rd_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_sb_pending   = pending_q;
  assign o_sb_stall_cnt = cnt_q;

endmodule

// File: tb/tb_riscv_pipe_scoreboard.sv
// Scoreboard bench: the stimulus thread queues expected outputs for each
// cycle, a monitor on the falling edge pops and compares them.
module tb_riscv_pipe_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       valid_d, used1_d, used2_d, wr_d, mc_d;
  logic [4:0] rs1_d, rs2_d, rd_d;
  logic       valid_e, wr_e, load_e, mc_e, redirect_e;
  logic [4:0] rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic       wr_m, wr_w, mc_done, cnt_clr;

  logic        sf0, sd0, fd0, fe0, st0, bz0;
  logic [1:0]  fa0, fb0;
  logic [31:0] pd0;
  logic [15:0] cnt0;
  logic        sf1, sd1, fd1, fe1, st1, bz1;
  logic [1:0]  fa1, fb1;
  logic [31:0] pd1;
  logic [3:0]  cnt1;

  riscv_pipe_scoreboard u_dut0 (
    .i_clk(clk), .i_rst(rst),
    .i_sb_valid_d(valid_d), .i_sb_rs1_addr_d(rs1_d), .i_sb_rs2_addr_d(rs2_d),
    .i_sb_rs1_used_d(used1_d), .i_sb_rs2_used_d(used2_d), .i_sb_rd_addr_d(rd_d),
    .i_sb_reg_wr_en_d(wr_d), .i_sb_mc_d(mc_d), .i_sb_valid_e(valid_e),
    .i_sb_rs1_addr_e(rs1_e), .i_sb_rs2_addr_e(rs2_e), .i_sb_rd_addr_e(rd_e),
    .i_sb_reg_wr_en_e(wr_e), .i_sb_load_e(load_e), .i_sb_mc_e(mc_e),
    .i_sb_redirect_e(redirect_e), .i_sb_rd_addr_m(rd_m), .i_sb_rd_addr_w(rd_w),
    .i_sb_reg_wr_en_m(wr_m), .i_sb_reg_wr_en_w(wr_w), .i_sb_mc_done(mc_done),
    .i_sb_cnt_clr(cnt_clr),
    .o_sb_stall_f(sf0), .o_sb_stall_d(sd0), .o_sb_flush_d(fd0), .o_sb_flush_e(fe0),
    .o_sb_forward_ae(fa0), .o_sb_forward_be(fb0), .o_sb_mc_start(st0),
    .o_sb_mc_busy(bz0), .o_sb_pending(pd0), .o_sb_stall_cnt(cnt0)
  );

  riscv_pipe_scoreboard #(.FWD_EN(0), .CNT_W(4)) u_dut1 (
    .i_clk(clk), .i_rst(rst),
    .i_sb_valid_d(valid_d), .i_sb_rs1_addr_d(rs1_d), .i_sb_rs2_addr_d(rs2_d),
    .i_sb_rs1_used_d(used1_d), .i_sb_rs2_used_d(used2_d), .i_sb_rd_addr_d(rd_d),
    .i_sb_reg_wr_en_d(wr_d), .i_sb_mc_d(mc_d), .i_sb_valid_e(valid_e),
    .i_sb_rs1_addr_e(rs1_e), .i_sb_rs2_addr_e(rs2_e), .i_sb_rd_addr_e(rd_e),
    .i_sb_reg_wr_en_e(wr_e), .i_sb_load_e(load_e), .i_sb_mc_e(mc_e),
    .i_sb_redirect_e(redirect_e), .i_sb_rd_addr_m(rd_m), .i_sb_rd_addr_w(rd_w),
    .i_sb_reg_wr_en_m(wr_m), .i_sb_reg_wr_en_w(wr_w), .i_sb_mc_done(mc_done),
    .i_sb_cnt_clr(cnt_clr),
    .o_sb_stall_f(sf1), .o_sb_stall_d(sd1), .o_sb_flush_d(fd1), .o_sb_flush_e(fe1),
    .o_sb_forward_ae(fa1), .o_sb_forward_be(fb1), .o_sb_mc_start(st1),
    .o_sb_mc_busy(bz1), .o_sb_pending(pd1), .o_sb_stall_cnt(cnt1)
  );

  // Check masks: control, forward, multi-cycle, pending, counter
  localparam logic [4:0] MC = 5'd1, MF = 5'd2, MM = 5'd4, MP = 5'd8, MN = 5'd16;
  localparam logic [4:0] MA = 5'd31;

  typedef struct {
    int          dut;
    string       name;
    logic [4:0]  m;
    logic        stall, fd, fe;
    logic [1:0]  fa, fb;
    logic        st, bz;
    logic [31:0] pd;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  exp_t        e;
  logic        a_sf, a_sd, a_fd, a_fe, a_st, a_bz;
  logic [1:0]  a_fa, a_fb;
  logic [31:0] a_pd;
  logic [15:0] a_cnt;

  // Monitor: compare every entry queued for the current cycle
  always @(negedge clk) begin
    while (q.size() > 0) begin
      e = q.pop_front();
      if (e.dut == 0) begin
        a_sf = sf0; a_sd = sd0; a_fd = fd0; a_fe = fe0; a_st = st0; a_bz = bz0;
        a_fa = fa0; a_fb = fb0; a_pd = pd0; a_cnt = cnt0;
      end else begin
        a_sf = sf1; a_sd = sd1; a_fd = fd1; a_fe = fe1; a_st = st1; a_bz = bz1;
        a_fa = fa1; a_fb = fb1; a_pd = pd1; a_cnt = {12'd0, cnt1};
      end
      if (e.m[0]) begin
        chk({e.name, " stall_f"}, 32'(a_sf), 32'(e.stall));
        chk({e.name, " stall_d"}, 32'(a_sd), 32'(e.stall));
        chk({e.name, " flush_d"}, 32'(a_fd), 32'(e.fd));
        chk({e.name, " flush_e"}, 32'(a_fe), 32'(e.fe));
      end
      if (e.m[1]) begin
        chk({e.name, " fwd_a"}, 32'(a_fa), 32'(e.fa));
        chk({e.name, " fwd_b"}, 32'(a_fb), 32'(e.fb));
      end
      if (e.m[2]) begin
        chk({e.name, " mc_start"}, 32'(a_st), 32'(e.st));
        chk({e.name, " mc_busy"}, 32'(a_bz), 32'(e.bz));
      end
      if (e.m[3]) chk({e.name, " pending"}, a_pd, e.pd);
      if (e.m[4]) chk({e.name, " stall_cnt"}, 32'(a_cnt), 32'(e.cnt));
    end
  end

  task automatic expect_out(input int dut, input string nm, input logic [4:0] m,
                            input logic stall, input logic fd, input logic fe,
                            input logic [1:0] fa, input logic [1:0] fb,
                            input logic st, input logic bz,
                            input logic [31:0] pd, input logic [15:0] cnt);
    exp_t x;
    x.dut = dut; x.name = nm; x.m = m; x.stall = stall; x.fd = fd; x.fe = fe;
    x.fa = fa; x.fb = fb; x.st = st; x.bz = bz; x.pd = pd; x.cnt = cnt;
    q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    valid_d = 0; used1_d = 0; used2_d = 0; wr_d = 0; mc_d = 0;
    rs1_d = 0; rs2_d = 0; rd_d = 0;
    valid_e = 0; wr_e = 0; load_e = 0; mc_e = 0; redirect_e = 0;
    rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
    wr_m = 0; wr_w = 0; mc_done = 0; cnt_clr = 0;
  endtask

  localparam logic [31:0] P7  = 32'h0000_0080;
  localparam logic [31:0] P12 = 32'h0000_1000;

  initial begin
    clr_in();
    rst = 1;
    tick();
    expect_out(0, "reset0", MA, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    expect_out(1, "reset1", MA, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    tick();
    rst = 0;

    // lw x5 in E, add x6,x5,x1 in D
    valid_e = 1; load_e = 1; wr_e = 1; rd_e = 5; rs1_e = 2; rs2_e = 3;
    valid_d = 1; rs1_d = 5; used1_d = 1; rs2_d = 1; used2_d = 1; rd_d = 6; wr_d = 1;
    expect_out(0, "load_use", MA, 1, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0);
    tick();
    // load now in W, add in E
    clr_in();
    wr_w = 1; rd_w = 5; valid_e = 1; wr_e = 1; rd_e = 6; rs1_e = 5; rs2_e = 1;
    expect_out(0, "lu_fwd_w", MA, 0, 0, 0, 2'b01, 2'b00, 0, 0, 0, 1);
    tick();
    // x3 in both M and W: M wins
    clr_in();
    wr_m = 1; rd_m = 3; wr_w = 1; rd_w = 3; valid_e = 1; rs1_e = 4; rs2_e = 3;
    expect_out(0, "fwd_m_prio", MA, 0, 0, 0, 2'b00, 2'b10, 0, 0, 0, 1);
    tick();
    // M writes x0: no match on x0, W still forwards x3
    rd_m = 0; rs1_e = 3; rs2_e = 0;
    expect_out(0, "fwd_x0", MA, 0, 0, 0, 2'b01, 2'b00, 0, 0, 0, 1);
    tick();

    // div x7 issues
    clr_in();
    valid_e = 1; mc_e = 1; wr_e = 1; rd_e = 7;
    expect_out(0, "div_issue", MA, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0, 1);
    tick();
    clr_in();
    valid_d = 1; rs1_d = 7; used1_d = 1; rd_d = 8; wr_d = 1;
    expect_out(0, "raw_pend1", MA, 1, 0, 1, 2'b00, 2'b00, 0, 1, P7, 1);
    tick();
    expect_out(0, "raw_pend2", MA, 1, 0, 1, 2'b00, 2'b00, 0, 1, P7, 2);
    tick();
    mc_done = 1;
    expect_out(0, "raw_done", MA, 1, 0, 1, 2'b00, 2'b00, 0, 1, P7, 3);
    tick();
    mc_done = 0;
    expect_out(0, "raw_release", MA, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 4);
    tick();

    // second div x7 issues while a mul sits in D
    clr_in();
    valid_e = 1; mc_e = 1; wr_e = 1; rd_e = 7;
    valid_d = 1; mc_d = 1; rd_d = 9; wr_d = 1;
    expect_out(0, "struct_start", MA, 1, 0, 1, 2'b00, 2'b00, 1, 0, 0, 4);
    tick();
    valid_e = 0; mc_e = 0; wr_e = 0; rd_e = 0;
    expect_out(0, "struct_busy", MA, 1, 0, 1, 2'b00, 2'b00, 0, 1, P7, 5);
    tick();
    // addi x7,x1 while x7 pending
    mc_d = 0; rd_d = 7; rs1_d = 1; used1_d = 1;
    expect_out(0, "waw", MA, 1, 0, 1, 2'b00, 2'b00, 0, 1, P7, 6);
    tick();
    rd_d = 9;
    expect_out(0, "no_hazard", MA, 0, 0, 0, 2'b00, 2'b00, 0, 1, P7, 7);
    tick();
    // redirect with a load-use stall pending
    clr_in();
    valid_e = 1; load_e = 1; wr_e = 1; rd_e = 5; redirect_e = 1;
    valid_d = 1; rs1_d = 5; used1_d = 1;
    expect_out(0, "redirect", MA, 0, 1, 1, 2'b00, 2'b00, 0, 1, P7, 7);
    tick();
    clr_in();
    mc_done = 1;
    expect_out(0, "done2", MA, 0, 0, 0, 2'b00, 2'b00, 0, 1, P7, 7);
    tick();
    mc_done = 0; cnt_clr = 1;
    expect_out(0, "cnt_clr", MA, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 7);
    tick();
    cnt_clr = 0; mc_done = 1;
    expect_out(0, "done_idle", MA, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    tick();
    mc_done = 0;
    expect_out(0, "after_done_idle", MM | MP, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    tick();
    // multi-cycle op writing x0 leaves the scoreboard clear
    valid_e = 1; mc_e = 1; wr_e = 1; rd_e = 0;
    expect_out(0, "mc_x0_issue", MM | MP, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0, 0);
    tick();
    clr_in();
    mc_done = 1;
    expect_out(0, "mc_x0_busy", MM | MP, 0, 0, 0, 2'b00, 2'b00, 0, 1, 0, 0);
    tick();
    mc_done = 0;
    expect_out(0, "mc_x0_done", MM | MP, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    tick();

    // stall-only build
    rst = 1;
    tick();
    rst = 0;
    valid_d = 1; rs1_d = 4; used1_d = 1; rd_d = 11; wr_d = 1;
    wr_m = 1; rd_m = 4; valid_e = 1; wr_e = 1; rd_e = 10; rs1_e = 4;
    expect_out(1, "nofwd_m", MA, 1, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0);
    expect_out(0, "fwd_on_m", MC | MF, 0, 0, 0, 2'b10, 2'b00, 0, 0, 0, 0);
    tick();
    wr_m = 0; rs1_d = 10;
    expect_out(1, "nofwd_e", MC | MN, 1, 0, 1, 2'b00, 2'b00, 0, 0, 0, 1);
    tick();
    wr_m = 1; rd_m = 0; rd_e = 0; rs1_d = 0; rs2_d = 0; used2_d = 1;
    expect_out(1, "nofwd_x0", MC | MN, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 2);
    tick();
    // continuous stall drives the 4-bit counter into saturation
    wr_m = 0; rd_e = 10; rs1_d = 10; used2_d = 0;
    for (int i = 0; i < 20; i++) tick();
    expect_out(1, "sat_hold1", MC | MN, 1, 0, 1, 2'b00, 2'b00, 0, 0, 0, 16'h000F);
    tick();
    expect_out(1, "sat_hold2", MN, 1, 0, 1, 2'b00, 2'b00, 0, 0, 0, 16'h000F);
    cnt_clr = 1;
    tick();
    cnt_clr = 0;
    expect_out(1, "clr_prio", MC | MN, 1, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0);
    tick();
    expect_out(1, "cnt_resume", MN, 1, 0, 1, 2'b00, 2'b00, 0, 0, 0, 1);
    tick();
    // reset while a multi-cycle op is outstanding
    clr_in();
    valid_e = 1; mc_e = 1; wr_e = 1; rd_e = 12;
    expect_out(1, "mid_issue", MC | MM | MP, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0, 0);
    tick();
    clr_in();
    expect_out(1, "mid_busy", MM | MP | MN, 0, 0, 0, 2'b00, 2'b00, 0, 1, P12, 2);
    tick();
    rst = 1;
    tick();
    rst = 0; mc_done = 1;
    expect_out(1, "rst_busy", MA, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    tick();
    mc_done = 0;
    expect_out(1, "late_done", MA, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    tick();

    for (int i = 0; i < 5 && q.size() > 0; i++) tick();
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, 0 required", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
